inst_fetch_queue: RTL



---
 rtl/fetchq_pkg.sv | 14 +
 rtl/fetchq_ram.sv | 27 ++
 rtl/inst_fetch_queue.sv | 98 +++++++++
 3 files changed

// File: rtl/fetchq_pkg.sv
// rtl/fetchq_pkg.sv - shared types and constants for the instruction fetch queue
package fetchq_pkg;

   localparam int FETCHQ_DEPTH = 4;
   localparam int FETCHQ_XLEN  = 32;

   localparam logic [FETCHQ_XLEN-1:0] NOP_INST = 32'h00000013;

   typedef struct packed {
      logic [FETCHQ_XLEN-1:0] pc;
      logic [FETCHQ_XLEN-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetchq_ram.sv
// rtl/fetchq_ram.sv - DEPTH x fetch_entry_t register array, sync write, async read
module fetchq_ram
   import fetchq_pkg::*;
#(
   parameter int DEPTH = FETCHQ_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  fetch_entry_t  wdata_i,
   input  logic [AW-1:0] raddr_i,
   output fetch_entry_t  rdata_o
);

   fetch_entry_t mem_q [DEPTH];

   // Data carries no reset; validity is tracked entirely by the pointers.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - IFU-to-decode decoupling FIFO with flush; FETCHQ_BYPASS_EN enables empty-queue bypass
module inst_fetch_queue
   import fetchq_pkg::*;
#(
   parameter int DEPTH = FETCHQ_DEPTH,
   parameter int XLEN  = FETCHQ_XLEN
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic [XLEN-1:0]          in_pc,
   input  logic [XLEN-1:0]          in_inst,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [XLEN-1:0]          out_pc,
   output logic [XLEN-1:0]          out_inst,
   input  logic                     out_ready,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic          empty, full;
   logic          push, pop, bypass, ram_we;
   fetch_entry_t  wentry, head;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

`ifdef FETCHQ_BYPASS_EN
   assign bypass = empty & in_valid & ~flush;
`else
   assign bypass = 1'b0;
`endif

   assign push = in_valid & ~full;
   assign pop  = ~empty & out_ready;
   // A bypassed entry that decode takes immediately never touches storage.
   assign ram_we = push & ~flush & ~(bypass & out_ready);

   assign wentry.pc   = in_pc;
   assign wentry.inst = in_inst;

   fetchq_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk_i   (clk),
      .we_i    (ram_we),
      .waddr_i (wr_ptr_q[AW-1:0]),
      .wdata_i (wentry),
      .raddr_i (rd_ptr_q[AW-1:0]),
      .rdata_o (head)
   );

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (ram_we) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   assign in_ready  = ~full;
   assign out_valid = ~empty | bypass;
   assign count     = wr_ptr_q - rd_ptr_q;

   always_comb begin
      out_pc   = '0;
      out_inst = NOP_INST;
      if (bypass) begin
         out_pc   = in_pc;
         out_inst = in_inst;
      end else if (!empty) begin
         out_pc   = head.pc;
         out_inst = head.inst;
      end
   end

endmodule
